// File: rtl/cbc_pkg.sv
// Shared types, widths and helpers for the cbc_dig controller and its PWM stage.
package cbc_pkg;

  localparam int unsigned DUTY_W = 14;
  localparam int unsigned MAG_W  = DUTY_W - 1;

  localparam logic [DUTY_W-1:0] NEG_FULL = 14'h2000;
  localparam logic [DUTY_W-1:0] POSACK   = 14'h1FFF;
  localparam logic [DUTY_W-1:0] NEGACK   = 14'h2001;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DEAD = 2'd3
  } pwm_state_t;

  // |d| as MAG_W bits; the most negative code saturates instead of wrapping
  function automatic logic [MAG_W-1:0] duty_mag(input logic [DUTY_W-1:0] d);
    logic [DUTY_W-1:0] neg;
    neg = ~d + DUTY_W'(1);
    if (d == NEG_FULL) begin
      duty_mag = '1;
    end else if (d[DUTY_W-1]) begin
      duty_mag = neg[MAG_W-1:0];
    end else begin
      duty_mag = d[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/duty_pwm_if.sv
// Duty-word write port and PWM outputs between cbc_dig and duty_pwm.
interface duty_pwm_if;

  logic [cbc_pkg::DUTY_W-1:0] duty;
  logic                       wrt_duty;
  logic                       CH_A;
  logic                       CH_B;
  logic                       prd_strt;

  modport master (
    output duty,
    output wrt_duty,
    input  CH_A,
    input  CH_B,
    input  prd_strt
  );

  modport slave (
    input  duty,
    input  wrt_duty,
    output CH_A,
    output CH_B,
    output prd_strt
  );

endinterface

// File: rtl/duty_pwm.sv
// Double-buffered, sign-steered PWM with dead-time on direction reversal
// and a period-start strobe for pacing the control loop.
module duty_pwm
  import cbc_pkg::*;
#(
  parameter int unsigned CNT_W    = 13,
  parameter int unsigned DEAD_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  duty_pwm_if.slave  pwm
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC - 1);

  pwm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              last_dir_q, last_dir_d;
  logic              last_dir_vld_q, last_dir_vld_d;
  logic              ch_a_q, ch_a_d;
  logic              ch_b_q, ch_b_d;
  logic              prd_strt_q, prd_strt_d;

  logic              boundary;
  logic [MAG_W-1:0]  mag_d;
  logic              dir_d;
  logic              pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      last_dir_q     <= 1'b0;
      last_dir_vld_q <= 1'b0;
      ch_a_q         <= 1'b0;
      ch_b_q         <= 1'b0;
      prd_strt_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      last_dir_q     <= last_dir_d;
      last_dir_vld_q <= last_dir_vld_d;
      ch_a_q         <= ch_a_d;
      ch_b_q         <= ch_b_d;
      prd_strt_q     <= prd_strt_d;
    end
  end

  // Outputs are computed from next-cycle state/count so they line up with cnt_q
  always_comb begin
    cnt_d          = cnt_q + CNT_W'(1);
    shadow_d       = shadow_q;
    active_d       = active_q;
    state_d        = state_q;
    last_dir_d     = last_dir_q;
    last_dir_vld_d = last_dir_vld_q;
    boundary       = (cnt_q == CNT_MAX);

    if (pwm.wrt_duty) begin
      shadow_d = pwm.duty;
    end
    if (boundary) begin
      active_d = pwm.wrt_duty ? pwm.duty : shadow_q;
    end

    mag_d = duty_mag(active_d);
    dir_d = active_d[DUTY_W-1];

    if (boundary) begin
      if (mag_d == '0) begin
        state_d = OFF;
      end else if (!last_dir_vld_q || (dir_d == last_dir_q)) begin
        state_d        = dir_d ? REV : FWD;
        last_dir_d     = dir_d;
        last_dir_vld_d = 1'b1;
      end else begin
        state_d    = DEAD;
        last_dir_d = dir_d;
      end
    end else if ((state_q == DEAD) && (cnt_q == DEAD_END)) begin
      state_d = last_dir_q ? REV : FWD;
    end

    pulse      = (32'(cnt_d) < 32'(mag_d));
    ch_a_d     = (state_d == FWD) && pulse;
    ch_b_d     = (state_d == REV) && pulse;
    prd_strt_d = (cnt_d == '0);
  end

  assign pwm.CH_A     = ch_a_q;
  assign pwm.CH_B     = ch_b_q;
  assign pwm.prd_strt = prd_strt_q;

endmodule

// File: tb/tb_duty_pwm.sv
// Self-checking bench for duty_pwm: per-period pulse records checked against a
// scoreboard of expected pulse windows pushed as each period is entered.
module tb_duty_pwm;

  localparam int PRD  = 8192;
  localparam int DEAD = 64;

  typedef struct {
    int a_hi;
    int a_first;
    int b_hi;
    int b_first;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  duty_pwm_if pwm ();

  duty_pwm #(
    .CNT_W   (13),
    .DEAD_CYC(DEAD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pwm  (pwm)
  );

  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_now();
    return cyc % PRD;
  endfunction

  // Per-period observation record, closed out in the last cycle of the period
  int   c_m, r_a_hi, r_a_first, r_a_last, r_b_hi, r_b_first, r_b_last, r_ovl, r_strt_bad;
  exp_t e_m;

  always @(negedge clk) begin
    if (rst_n) begin
      c_m = cnt_now();
      if (c_m == 0) begin
        r_a_hi = 0; r_a_first = -1; r_a_last = -1;
        r_b_hi = 0; r_b_first = -1; r_b_last = -1;
        r_ovl = 0;  r_strt_bad = 0;
      end
      if (pwm.CH_A) begin
        if (r_a_first < 0) r_a_first = c_m;
        r_a_last = c_m;
        r_a_hi++;
      end
      if (pwm.CH_B) begin
        if (r_b_first < 0) r_b_first = c_m;
        r_b_last = c_m;
        r_b_hi++;
      end
      if (pwm.CH_A && pwm.CH_B) r_ovl++;
      if (pwm.prd_strt != ((c_m == 0) && (cyc != 0))) r_strt_bad++;
      if ((c_m == PRD - 1) && (sb.size() > 0)) begin
        e_m = sb.pop_front();
        chk("a_hi",     r_a_hi,    e_m.a_hi);
        chk("a_first",  r_a_first, (e_m.a_hi > 0) ? e_m.a_first : -1);
        chk("a_last",   r_a_last,  (e_m.a_hi > 0) ? e_m.a_first + e_m.a_hi - 1 : -1);
        chk("b_hi",     r_b_hi,    e_m.b_hi);
        chk("b_first",  r_b_first, (e_m.b_hi > 0) ? e_m.b_first : -1);
        chk("b_last",   r_b_last,  (e_m.b_hi > 0) ? e_m.b_first + e_m.b_hi - 1 : -1);
        chk("overlap",  r_ovl,      0);
        chk("prd_strt", r_strt_bad, 0);
      end
    end
  end

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cnt_now() != c) && (n < 2 * PRD));
    if (cnt_now() != c) chk("wait_cnt_timeout", cnt_now(), c);
  endtask

  // c==0 drives in the current cycle (caller is already at cnt 0)
  task automatic write_at(input int c, input logic [13:0] v);
    if (c != 0) wait_cnt(c);
    pwm.duty     = v;
    pwm.wrt_duty = 1'b1;
    @(posedge clk);
    #1 pwm.wrt_duty = 1'b0;
  endtask

  task automatic period(input int ah, input int af, input int bh, input int bf);
    exp_t e;
    wait_cnt(0);
    e.a_hi = ah; e.a_first = af; e.b_hi = bh; e.b_first = bf;
    sb.push_back(e);
  endtask

  initial begin
    pwm.duty     = '0;
    pwm.wrt_duty = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ch_a",     int'(pwm.CH_A),     0);
    chk("rst_ch_b",     int'(pwm.CH_B),     0);
    chk("rst_prd_strt", int'(pwm.prd_strt), 0);
    rst_n = 1'b1;

    // Reset asserted mid-pulse with 0x0800 running
    write_at(100, 14'h0800);
    wait_cnt(0);
    wait_cnt(1000);
    chk("pre_reset_ch_a", int'(pwm.CH_A), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_ch_a",     int'(pwm.CH_A),     0);
    chk("mid_reset_ch_b",     int'(pwm.CH_B),     0);
    chk("mid_reset_prd_strt", int'(pwm.prd_strt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First strobe latency, with two writes in that period (last wins)
    fork
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          n++;
          #1;
        end while (!pwm.prd_strt && (n < 2 * PRD));
        chk("first_prd_strt_delay", n, PRD);
      end
      begin
        write_at(100,  14'h0200);
        write_at(4000, 14'h0300);
      end
    join

    period(768, 0, 0, 0);
    write_at(PRD - 1, 14'h0100);
    period(256, 0, 0, 0);
    write_at(0, 14'h3800);
    period(0, 0, 2048 - DEAD, DEAD);
    write_at(10, 14'h2000);
    period(0, 0, PRD - 1, 0);
    write_at(10, 14'h0000);
    period(0, 0, 0, 0);
    write_at(10, 14'h0800);
    period(2048 - DEAD, DEAD, 0, 0);
    write_at(10, 14'h3FE0);
    period(0, 0, 0, 0);
    period(0, 0, 32, 0);

    wait_cnt(PRD - 1);
    @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duty_pwm.md
# duty_pwm

PWM output stage directly downstream of the `cbc_dig` controller datapath. It accepts the 14-bit signed duty word that the control loop drives on `dst`, qualified by `wrt_duty`, and double-buffers it. At each period boundary it produces sign-steered PWM on `CH_A`/`CH_B`, with a guaranteed dead-time whenever the drive direction reverses. It also emits a period-start strobe so the controller can pace its calculation loop.

## Interface
- `CNT_W`, 13: period counter width. The period is 2^CNT_W clocks (8192).
- `DEAD_CYC`, 64: number of both-low clocks inserted at the start of a period after a direction reversal. Legal range is 1..2^CNT_W-1.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `duty`  in  14: signed two's-complement duty (0x2000..0x1FFF). Driven from `dst`.
- `wrt_duty`  in  1: single-cycle strobe that captures `duty` into the shadow register.
- `CH_A`  out  1: forward drive, registered.
- `CH_B`  out  1: reverse drive, registered.
- `prd_strt`  out  1: one-cycle pulse in the first cycle of each period (cnt==0).

## Operation
**Counter**
- `cnt` is CNT_W bits and free-running. It increments every clock and wraps 8191→0.
- The boundary is the cycle in which cnt==8191.

**Shadow and active registers**
- `wrt_duty` loads `shadow` ← `duty`. If several writes land in one period, the last one wins.
- At the boundary, `active` ← `shadow`.
- If `wrt_duty` is high in the boundary cycle itself, the incoming `duty` bypasses `shadow` and is loaded into `active` directly.

**Magnitude and sign (computed from `active`)**
- `dir` = `active[13]` (1 means reverse).
- `mag` = |active| as 13 bits.
- -8192 (0x2000) saturates to 8191. There is no wrap.

**FSM: states OFF, FWD, REV, DEAD**
- A boundary transition is evaluated only at the boundary.
- If mag==0: next state is OFF. `last_dir` is retained.
- If mag!=0 and dir==`last_dir`, or `last_dir` is unset (after reset): next state is FWD or REV per `dir`.
- If mag!=0 and dir!=`last_dir`: next state is DEAD. `last_dir` ← dir.
- DEAD→FWD/REV (per `last_dir`) in the cycle in which cnt==DEAD_CYC-1.
- A boundary arriving while in DEAD uses the boundary transition rules.

**Outputs**
- FWD: `CH_A` = (cnt < mag), `CH_B` = 0.
- REV: `CH_B` = (cnt < mag), `CH_A` = 0.
- OFF and DEAD: both outputs 0. The pulse lost to DEAD is not stretched, so if mag ≤ DEAD_CYC there is no pulse that period.
- Invariant: `CH_A` & `CH_B` is never 1.

## Timing
**Reset (asynchronous)**
- cnt=0, shadow=0, active=0.
- state=OFF, `last_dir` unset.
- `CH_A`=`CH_B`=0, `prd_strt`=0.
- Asserting reset mid-pulse drops the outputs immediately. The first post-reset `prd_strt` occurs 8192 clocks after deassertion.

**Output alignment**
- The output flops are fed from next-state/next-cnt logic, so `CH_A`/`CH_B` align with the cnt value of the same cycle.
- FWD with mag=M gives `CH_A` high exactly for cnt 0..M-1, i.e. M clocks per period.
- mag=8191 gives high for 8191 clocks and low for 1.

**Latency**
- `wrt_duty` → effect at the next cnt==0. That is 1 to 8192 clocks; it is 1 clock when the write lands in the boundary cycle.

**Strobe**
- `prd_strt` is high exactly in cycles with cnt==0.
- A `wrt_duty` arriving in the same cycle as `prd_strt` goes to `shadow` and is applied at the following boundary.

## Structure
- Shared package `cbc_pkg` holds:
  - state enum `pwm_state_t` {OFF, FWD, REV, DEAD};
  - `DUTY_W`=14;
  - `NEG_FULL`=14'h2000;
  - `POSACK`/`NEGACK` constants if they are not already present.
- Single module. The magnitude/saturation function lives in `cbc_pkg` as a function. No sub-module is warranted.

## Test plan
1. Reset asserted mid-pulse with duty 0x0800 → `CH_A`, `CH_B`, `prd_strt` all 0 within the same cycle; first `prd_strt` 8192 clocks after release.
2. `wrt_duty` with 0x0800 → from the next cnt==0, `CH_A` high for 2048 clocks per 8192-clock period, `CH_B` never high.
3. 0x0800 running, then write 0x3800 (-2048) → next period: both low for cnt 0..63, `CH_B` high for cnt 64..2047; subsequent periods: `CH_B` high for cnt 0..2047; `CH_A`&`CH_B` never 1.
4. Write 0x2000 → `CH_B` high 8191 clocks, low 1 per period (saturation); then write 0x0000 → both low, OFF.
5. Write 0x0100 in the cnt==8191 cycle → `CH_A` high 256 clocks starting the next cycle. Separately, writes of 0x0200 and then 0x0300 within one period → only 0x0300 (768 clocks) is applied.
6. Reversal with mag ≤ DEAD_CYC (0x0800 → 0x3FE0, i.e. -32) → that period has no pulse on either channel; the following period has `CH_B` high for cnt 0..31.
